// File: rtl/mig_node_sequencer_pkg.sv
// Shared types and constants for the MIG node sequencer.
package mig_seq_pkg;

  localparam int unsigned NUM_IN    = 4;
  localparam int unsigned MAX_NODES = 8;
  localparam int unsigned SEL_W     = 4;

  localparam logic [SEL_W-1:0] SEL_CONST0 = 4'd0;
  localparam logic [SEL_W-1:0] SEL_X0     = 4'd1;
  localparam logic [SEL_W-1:0] SEL_N0     = 4'd5;
  localparam logic [SEL_W-1:0] SEL_MAX    = 4'd12;

  typedef struct packed {
    logic             inv;
    logic [SEL_W-1:0] sel;
  } operand_t;

  // Field order matches cfg_node = {inv_c,sel_c,inv_b,sel_b,inv_a,sel_a}.
  typedef struct packed {
    operand_t c;
    operand_t b;
    operand_t a;
  } node_t;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    DONE
  } state_e;

endpackage

// File: rtl/mig_node_sequencer_maj3.sv
// Shared three-input majority evaluator with per-operand complement.
module mig_maj3 (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic inv_a,
  input  logic inv_b,
  input  logic inv_c,
  output logic maj
);

  logic ea, eb, ec;

  always_comb begin
    ea  = a ^ inv_a;
    eb  = b ^ inv_b;
    ec  = c ^ inv_c;
    maj = (ea & eb) | (ea & ec) | (eb & ec);
  end

endmodule

// File: rtl/mig_node_sequencer.sv
// Time-multiplexed MIG netlist evaluator: one node per cycle, single vector or 16-vector sweep.
module mig_node_sequencer
  import mig_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_addr,
  input  logic [14:0] cfg_node,
  input  logic        cfg_ctl_we,
  input  logic [3:0]  cfg_len,
  input  logic        cfg_out_inv,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic        start_sweep,
  input  logic [3:0]  start_x,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_tt,
  output logic        res_err
);

  state_e                    state_q, state_d;
  node_t [MAX_NODES-1:0]     table_q, table_d;
  node_t [MAX_NODES-1:0]     run_tbl_q, run_tbl_d;
  logic [3:0]                len_q, len_d, run_len_q, run_len_d;
  logic                      out_inv_q, out_inv_d, run_inv_q, run_inv_d;
  logic                      sweep_q, sweep_d;
  logic [3:0]                x_q, x_d, pat_q, pat_d;
  logic [2:0]                k_q, k_d;
  logic [MAX_NODES-1:0]      nval_q, nval_d;
  logic [15:0]               tt_q, tt_d;
  logic                      err_q, err_d;

  node_t          cur;
  operand_t [2:0] ops;
  logic [2:0]     raw, inv;
  logic [3:0]     x_cur;
  logic           bad, node_val, last_node, y;

  // Illegal selects (forward/self node or out of range) read as 0 before inversion.
  always_comb begin
    cur   = run_tbl_q[k_q];
    ops   = {cur.c, cur.b, cur.a};
    x_cur = sweep_q ? pat_q : x_q;
    bad   = 1'b0;
    raw   = '0;
    inv   = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      inv[i] = ops[i].inv;
      if (ops[i].sel > SEL_MAX || ops[i].sel >= SEL_N0 + {1'b0, k_q}) begin
        bad = 1'b1;
      end else if (ops[i].sel >= SEL_N0) begin
        raw[i] = nval_q[3'(ops[i].sel - SEL_N0)];
      end else if (ops[i].sel >= SEL_X0) begin
        raw[i] = x_cur[2'(ops[i].sel - SEL_X0)];
      end
    end
  end

  mig_maj3 u_maj (
    .a     (raw[0]),
    .b     (raw[1]),
    .c     (raw[2]),
    .inv_a (inv[0]),
    .inv_b (inv[1]),
    .inv_c (inv[2]),
    .maj   (node_val)
  );

  always_comb begin
    last_node = (k_q == 3'(run_len_q - 4'd1));
    y         = node_val ^ run_inv_q;
  end

  always_comb begin
    state_d   = state_q;
    table_d   = table_q;
    run_tbl_d = run_tbl_q;
    len_d     = len_q;
    run_len_d = run_len_q;
    out_inv_d = out_inv_q;
    run_inv_d = run_inv_q;
    sweep_d   = sweep_q;
    x_d       = x_q;
    pat_d     = pat_q;
    k_d       = k_q;
    nval_d    = nval_q;
    tt_d      = tt_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (cfg_we) table_d[cfg_addr] = node_t'(cfg_node);
        if (cfg_ctl_we && cfg_len != 4'd0 && cfg_len <= 4'(MAX_NODES)) begin
          len_d     = cfg_len;
          out_inv_d = cfg_out_inv;
        end
        // Snapshot from the pre-write registers so a same-cycle cfg write affects only later runs.
        if (start_valid) begin
          state_d   = EVAL;
          sweep_d   = start_sweep;
          x_d       = start_x;
          run_len_d = len_q;
          run_inv_d = out_inv_q;
          run_tbl_d = table_q;
          nval_d    = '0;
          pat_d     = '0;
          k_d       = '0;
          err_d     = 1'b0;
          tt_d      = '0;
        end
      end
      EVAL: begin
        nval_d[k_q] = node_val;
        if (bad) err_d = 1'b1;
        if (last_node) begin
          tt_d[pat_q] = y;
          k_d         = '0;
          if (!sweep_q || pat_q == 4'hF) state_d = DONE;
          else                           pat_d   = pat_q + 4'd1;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      table_q   <= '0;
      run_tbl_q <= '0;
      len_q     <= 4'd1;
      run_len_q <= 4'd1;
      out_inv_q <= 1'b0;
      run_inv_q <= 1'b0;
      sweep_q   <= 1'b0;
      x_q       <= '0;
      pat_q     <= '0;
      k_q       <= '0;
      nval_q    <= '0;
      tt_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      table_q   <= table_d;
      run_tbl_q <= run_tbl_d;
      len_q     <= len_d;
      run_len_q <= run_len_d;
      out_inv_q <= out_inv_d;
      run_inv_q <= run_inv_d;
      sweep_q   <= sweep_d;
      x_q       <= x_d;
      pat_q     <= pat_d;
      k_q       <= k_d;
      nval_q    <= nval_d;
      tt_q      <= tt_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    start_ready = (state_q == IDLE);
    res_valid   = (state_q == DONE);
    res_tt      = tt_q;
    res_err     = err_q;
  end

endmodule
